reg_file_rename: RTL

Architectural register file with per-register ROB-tag renaming. It is the consumer end of the ROB's rename/commit interface. It records which ROB entry will produce each register (upd_*) and retires committed values (write_*). For each decoded source operand it returns either a ready value or the ROB tag, which the ROB then resolves through its rs1_idx/rs2_idx lookup. It sits between the Decoder and the ROB.

---
 rtl/reg_file_rename.sv | 99 +++++++++
 1 files changed

// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with per-register ROB-tag renaming
module reg_file_rename #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RBW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            jp_wrong,
    input  logic [4:0]      rs1_ID,
    input  logic [4:0]      rs2_ID,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val,
    output logic [RBW-1:0]  rs1_idx,
    output logic [RBW-1:0]  rs2_idx,
    input  logic            upd_flag,
    input  logic [RBW-1:0]  upd_idx,
    input  logic [4:0]      upd_rd,
    input  logic            write_flag,
    input  logic [RBW-1:0]  write_idx,
    input  logic [4:0]      write_rd,
    input  logic [XLEN-1:0] new_val
);

    logic [XLEN-1:0] regs [NREG];
    logic [RBW-1:0]  tag  [NREG];
    logic [NREG-1:0] busy;

    logic commit_ok;
    logic rename_ok;

    assign commit_ok = write_flag && !jp_wrong && (write_rd != 5'd0);
    assign rename_ok = upd_flag && !jp_wrong && (upd_rd != 5'd0);

    // A same-cycle commit is forwarded to readers; only a matching tag clears busy.
    always_comb begin
        rs1_busy = busy[rs1_ID];
        rs1_val  = regs[rs1_ID];
        rs1_idx  = tag[rs1_ID];
        if (commit_ok && (write_rd == rs1_ID)) begin
            rs1_val = new_val;
            if (tag[rs1_ID] == write_idx) begin
                rs1_busy = 1'b0;
            end
        end
        if (rs1_ID == 5'd0) begin
            rs1_busy = 1'b0;
            rs1_val  = '0;
            rs1_idx  = '0;
        end
    end

    always_comb begin
        rs2_busy = busy[rs2_ID];
        rs2_val  = regs[rs2_ID];
        rs2_idx  = tag[rs2_ID];
        if (commit_ok && (write_rd == rs2_ID)) begin
            rs2_val = new_val;
            if (tag[rs2_ID] == write_idx) begin
                rs2_busy = 1'b0;
            end
        end
        if (rs2_ID == 5'd0) begin
            rs2_busy = 1'b0;
            rs2_val  = '0;
            rs2_idx  = '0;
        end
    end

    // Rename is applied after commit so it wins the busy bit on a shared rd.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                tag[i]  <= '0;
            end
        end else if (rdy) begin
            if (jp_wrong) begin
                busy <= '0;
            end else begin
                if (commit_ok) begin
                    regs[write_rd] <= new_val;
                    if (tag[write_rd] == write_idx) begin
                        busy[write_rd] <= 1'b0;
                    end
                end
                if (rename_ok) begin
                    busy[upd_rd] <= 1'b1;
                    tag[upd_rd]  <= upd_idx;
                end
            end
        end
    end

endmodule
